// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: stalls, flushes, boot sequencing,
// trap entry and ERET return for a four-stage-register pipeline.
module pipe_ctrl #(
    parameter logic [29:0] RESET_VECTOR = 30'h0000000,
    parameter logic [29:0] EXP_VECTOR   = 30'h0000004,
    parameter int unsigned BOOT_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_busy,
    input  logic        mem_busy,
    input  logic        ld_hazard,
    input  logic        mem_en,
    input  logic [29:0] mem_pc,
    input  logic [2:0]  mem_exp_code,
    input  logic        mem_eret,
    input  logic        int_req,
    input  logic        int_en,
    output logic        if_stall,
    output logic        id_stall,
    output logic        ex_stall,
    output logic        mem_stall,
    output logic        if_flush,
    output logic        id_flush,
    output logic        ex_flush,
    output logic        mem_flush,
    output logic [29:0] new_pc,
    output logic        new_pc_valid,
    output logic [29:0] epc,
    output logic [2:0]  exp_cause,
    output logic        busy_trap
);

    localparam int unsigned PC_W   = 30;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    boot_cnt_q, boot_cnt_d;
    logic [PC_W-1:0]     epc_q, epc_d;
    logic [CODE_W-1:0]   cause_q, cause_d;

    logic stall_all;
    logic evt_ok;
    logic take_exp;
    logic take_int;
    logic take_eret;

    assign stall_all = if_busy | mem_busy;
    assign evt_ok    = mem_en & ~mem_busy;
    assign take_exp  = evt_ok & (|mem_exp_code);
    assign take_int  = evt_ok & ~(|mem_exp_code) & int_req & int_en;
    assign take_eret = evt_ok & ~(|mem_exp_code) & ~(int_req & int_en) & mem_eret;

    assign id_stall  = stall_all;
    assign ex_stall  = stall_all;
    assign mem_stall = stall_all;

    // Next-state, redirect and flush decode
    always_comb begin
        state_d      = state_q;
        boot_cnt_d   = boot_cnt_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        if_stall     = stall_all;
        if_flush     = 1'b0;
        id_flush     = 1'b0;
        ex_flush     = 1'b0;
        mem_flush    = 1'b0;
        new_pc       = '0;
        new_pc_valid = 1'b0;

        case (state_q)
            ST_BOOT: begin
                if_flush   = 1'b1;
                id_flush   = 1'b1;
                ex_flush   = 1'b1;
                mem_flush  = 1'b1;
                boot_cnt_d = boot_cnt_q - CNT_W'(1);
                // Gate with reset so a one-cycle boot does not redirect while held in reset
                if (boot_cnt_q <= CNT_W'(1)) begin
                    new_pc       = RESET_VECTOR;
                    new_pc_valid = reset;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (take_exp || take_int) begin
                    if_flush     = 1'b1;
                    id_flush     = 1'b1;
                    ex_flush     = 1'b1;
                    mem_flush    = 1'b1;
                    new_pc       = EXP_VECTOR;
                    new_pc_valid = 1'b1;
                    epc_d        = mem_pc;
                    cause_d      = take_exp ? mem_exp_code : CODE_W'(1);
                    state_d      = ST_TRAP;
                end else if (take_eret) begin
                    if_flush     = 1'b1;
                    id_flush     = 1'b1;
                    ex_flush     = 1'b1;
                    mem_flush    = 1'b1;
                    new_pc       = epc_q;
                    new_pc_valid = 1'b1;
                end else begin
                    if_stall = stall_all | ld_hazard;
                    id_flush = ld_hazard & ~stall_all;
                end
            end
            ST_TRAP: begin
                if (!stall_all) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= CNT_W'(BOOT_CYCLES);
            epc_q      <= '0;
            cause_q    <= '0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            epc_q      <= epc_d;
            cause_q    <= cause_d;
        end
    end

    assign epc       = epc_q;
    assign exp_cause = cause_q;
    assign busy_trap = (state_q == ST_TRAP);

endmodule
